// File: rtl/infra_mem_dwsn_resp.sv
// Memory-side responder: self-zeroizing SRAM model with fixed read latency and down-select.
// Optional error injection is enabled with `define INFRA_MEM_ERRINJ_EN.
module infra_mem_dwsn_resp #(
   parameter int WIDTH      = 32,
   parameter int ENAEXT     = 0,
   parameter int ENAPAR     = 0,
   parameter int ENAECC     = 0,
   parameter int ECCWDTH    = 7,
   parameter int MEMWDTH    = (ENAEXT != 0) ? WIDTH :
                              (ENAPAR != 0) ? WIDTH + 1 :
                              (ENAECC != 0) ? WIDTH + ECCWDTH : WIDTH,
   parameter int NUMWRDS    = 4,
   parameter int NUMSROW    = 256,
   parameter int BITSROW    = 8,
   parameter int NUMDWSN    = 2,
   parameter int BITDWSN    = 4,
   parameter int SRAM_DELAY = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [BITSROW-1:0]           mem_addr,
   input  logic [NUMWRDS*MEMWDTH-1:0]   mem_bw,
   input  logic [BITDWSN-1:0]           mem_dwsn,
   input  logic [NUMWRDS*MEMWDTH-1:0]   mem_din,
   output logic [NUMWRDS*MEMWDTH-1:0]   mem_dout,
   output logic [NUMWRDS-1:0]           mem_serr,
   output logic                         mem_vld,
   output logic                         mem_rdy,
   input  logic                         inj_req,
   input  logic [BITDWSN+BITSROW-1:0]   inj_addr,
   input  logic [$clog2(NUMWRDS)-1:0]   inj_word
);

   localparam int ROWW  = NUMWRDS * MEMWDTH;
   localparam int DEPTH = NUMDWSN * NUMSROW;
   localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   cnt_q, cnt_d;
   logic [ROWW-1:0]   mem_q [DEPTH];

   logic              dwsn_ok_s, row_ok_s, in_range_s, rdy_s, rd_ok_s, wr_ok_s;
   logic [IDXW-1:0]   idx_s;
   logic [ROWW-1:0]   rd_dat_s;
   logic [NUMWRDS-1:0] rd_serr_s;

   logic              vld_q  [SRAM_DELAY];
   logic [ROWW-1:0]   dat_q  [SRAM_DELAY];
   logic [NUMWRDS-1:0] serr_q [SRAM_DELAY];

   // Range compares only exist when the field can encode an unimplemented value.
   generate
      if (NUMDWSN < (2 ** BITDWSN)) begin : g_dwsn_chk
         assign dwsn_ok_s = (mem_dwsn < BITDWSN'(NUMDWSN));
      end else begin : g_dwsn_all
         assign dwsn_ok_s = 1'b1;
      end
      if (NUMSROW < (2 ** BITSROW)) begin : g_row_chk
         assign row_ok_s = (mem_addr < BITSROW'(NUMSROW));
      end else begin : g_row_all
         assign row_ok_s = 1'b1;
      end
   endgenerate

   assign in_range_s = dwsn_ok_s && row_ok_s;
   assign idx_s      = IDXW'(32'(mem_dwsn) * 32'(NUMSROW) + 32'(mem_addr));
   assign rdy_s      = (state_q == ST_READY);
   assign rd_ok_s    = rdy_s && mem_read;
   assign wr_ok_s    = rdy_s && mem_write && in_range_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + IDXW'(1);
            if (cnt_q == IDXW'(DEPTH - 1)) begin
               state_d = ST_READY;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Storage has no reset: INIT zeroes one row per cycle, then bitwise-masked writes.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_ok_s) begin
         mem_q[idx_s] <= (mem_q[idx_s] & ~mem_bw) | (mem_din & mem_bw);
      end
   end

`ifdef INFRA_MEM_ERRINJ_EN
   logic                         inj_vld_q, inj_vld_d;
   logic [BITDWSN+BITSROW-1:0]   inj_tgt_q, inj_tgt_d;
   logic [$clog2(NUMWRDS)-1:0]   inj_wrd_q, inj_wrd_d;
   logic                         inj_match_s, inj_hit_s;

   assign inj_match_s = inj_vld_q && in_range_s && (inj_tgt_q == {mem_dwsn, mem_addr});
   assign inj_hit_s   = inj_match_s && rd_ok_s;

   // A new request replaces the pending one; any access to the target row consumes it.
   always_comb begin
      inj_vld_d = inj_vld_q;
      inj_tgt_d = inj_tgt_q;
      inj_wrd_d = inj_wrd_q;
      if (rdy_s && inj_req) begin
         inj_vld_d = 1'b1;
         inj_tgt_d = inj_addr;
         inj_wrd_d = inj_word;
      end else if (rdy_s && inj_match_s && (mem_read || mem_write)) begin
         inj_vld_d = 1'b0;
      end else begin
         inj_vld_d = inj_vld_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inj_vld_q <= 1'b0;
         inj_tgt_q <= '0;
         inj_wrd_q <= '0;
      end else begin
         inj_vld_q <= inj_vld_d;
         inj_tgt_q <= inj_tgt_d;
         inj_wrd_q <= inj_wrd_d;
      end
   end
`else
   logic unused_inj_s;
   assign unused_inj_s = ^{inj_req, inj_addr, inj_word};
`endif

   always_comb begin
      rd_dat_s  = '0;
      rd_serr_s = '1;
      if (in_range_s) begin
         rd_dat_s  = mem_q[idx_s];
         rd_serr_s = '0;
      end else begin
         rd_dat_s  = '0;
         rd_serr_s = '1;
      end
`ifdef INFRA_MEM_ERRINJ_EN
      if (inj_hit_s) begin
         rd_dat_s  = rd_dat_s ^ (ROWW'(1) << (32'(inj_wrd_q) * MEMWDTH));
         rd_serr_s = rd_serr_s | (NUMWRDS'(1) << inj_wrd_q);
      end else begin
         rd_dat_s  = rd_dat_s;
      end
`endif
   end

   // Read pipeline: data holds when no valid passes, error flags only travel with valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SRAM_DELAY; i++) begin
            vld_q[i]  <= 1'b0;
            dat_q[i]  <= '0;
            serr_q[i] <= '0;
         end
      end else begin
         vld_q[0]  <= rd_ok_s;
         serr_q[0] <= rd_ok_s ? rd_serr_s : '0;
         if (rd_ok_s) begin
            dat_q[0] <= rd_dat_s;
         end
         for (int i = 1; i < SRAM_DELAY; i++) begin
            vld_q[i]  <= vld_q[i-1];
            serr_q[i] <= serr_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign mem_dout = dat_q[SRAM_DELAY-1];
   assign mem_serr = serr_q[SRAM_DELAY-1];
   assign mem_vld  = vld_q[SRAM_DELAY-1];
   assign mem_rdy  = rdy_s;

endmodule

// File: tb/tb_infra_mem_dwsn_resp.sv
// Self-checking bench for infra_mem_dwsn_resp: directed scenarios plus random traffic
// checked against an associative-array memory model and a due-cycle response queue.
module tb_infra_mem_dwsn_resp;
   localparam int MW = 32, NW = 4, RW = 128, NSROW = 256, NDW = 2, DLY = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_read, mem_write;
   logic [7:0]    mem_addr;
   logic [RW-1:0] mem_bw, mem_din, mem_dout;
   logic [3:0]    mem_dwsn, mem_serr;
   logic          mem_vld, mem_rdy;
   logic          inj_req;
   logic [11:0]   inj_addr;
   logic [1:0]    inj_word;

   always #5 clk = ~clk;

   infra_mem_dwsn_resp dut (
      .clk(clk), .rst(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_bw(mem_bw), .mem_dwsn(mem_dwsn), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_serr(mem_serr), .mem_vld(mem_vld), .mem_rdy(mem_rdy),
      .inj_req(inj_req), .inj_addr(inj_addr), .inj_word(inj_word)
   );

   typedef struct {int due; logic [RW-1:0] dat; logic [3:0] serr;} exp_t;

   int            n_pass = 0, n_total = 0, edge_n = 0;
   logic [RW-1:0] model [int];
   exp_t          expq [$];
   logic [RW-1:0] last_dout = '0;
   bit            inj_pend = 1'b0;
   int            inj_key = 0, inj_w = 0;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_out();
      exp_t e;
      if (expq.size() > 0 && expq[0].due == edge_n) begin
         e = expq.pop_front();
         chk("rd_vld", {127'd0, mem_vld}, 128'd1);
         chk("rd_dout", mem_dout, e.dat);
         chk("rd_serr", {124'd0, mem_serr}, {124'd0, e.serr});
         last_dout = e.dat;
      end else begin
         chk("idle_vld", {127'd0, mem_vld}, 128'd0);
         chk("idle_serr", {124'd0, mem_serr}, 128'd0);
         chk("idle_hold", mem_dout, last_dout);
      end
   endtask

   task automatic step(input bit rd, input bit wr, input int dw, input int row,
                       input logic [RW-1:0] bw, input logic [RW-1:0] din);
      int            key;
      bit            inr;
      logic [RW-1:0] dat;
      logic [3:0]    serr;
      mem_read = rd; mem_write = wr; mem_dwsn = dw[3:0]; mem_addr = row[7:0];
      mem_bw = bw; mem_din = din;
      @(posedge clk);
      edge_n++;
      key = dw * NSROW + row;
      inr = (dw < NDW) && (row < NSROW);
      if (rd) begin
         dat  = (inr && model.exists(key)) ? model[key] : '0;
         serr = inr ? 4'b0000 : 4'b1111;
`ifdef INFRA_MEM_ERRINJ_EN
         if (inj_pend && inr && key == inj_key) begin
            dat[inj_w * MW] = ~dat[inj_w * MW];
            serr[inj_w] = 1'b1;
         end
`endif
         expq.push_back('{edge_n + DLY - 1, dat, serr});
      end
`ifdef INFRA_MEM_ERRINJ_EN
      if (inj_req) begin
         inj_pend = 1'b1; inj_key = int'(inj_addr); inj_w = int'(inj_word);
      end else if (inj_pend && inr && key == inj_key && (rd || wr)) begin
         inj_pend = 1'b0;
      end
`endif
      if (wr && inr) begin
         dat = model.exists(key) ? model[key] : '0;
         model[key] = (dat & ~bw) | (din & bw);
      end
      #1;
      check_out();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, '0, '0);
   endtask

   // Commands driven during INIT must be ignored: a full-row write to row 0 and a read.
   task automatic wait_init();
      int n = 0;
      mem_read = 1'b1; mem_write = 1'b1; mem_dwsn = 4'd0; mem_addr = 8'd0;
      mem_bw = '1; mem_din = '1;
      chk("rdy_at_release", {127'd0, mem_rdy}, 128'd0);
      while (!mem_rdy && n < 2000) begin
         @(posedge clk);
         edge_n++;
         #1;
         n++;
         chk("init_vld", {127'd0, mem_vld}, 128'd0);
      end
      mem_read = 1'b0; mem_write = 1'b0;
      chk("init_len", 128'(n), 128'd512);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RW-1:0] bw_w2;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = 8'd0; mem_dwsn = 4'd0;
      mem_bw = '0; mem_din = '0; inj_req = 1'b0; inj_addr = 12'd0; inj_word = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vld", {127'd0, mem_vld}, 128'd0);
      chk("rst_rdy", {127'd0, mem_rdy}, 128'd0);
      chk("rst_dout", mem_dout, 128'd0);
      chk("rst_serr", {124'd0, mem_serr}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init();

      step(1'b1, 1'b0, 1, 255, '0, '0);
      chk("init_rd_early", {127'd0, mem_vld}, 128'd0);
      idle();
      chk("init_rd_vld", {127'd0, mem_vld}, 128'd1);
      chk("init_rd_dout", mem_dout, 128'd0);
      step(1'b1, 1'b0, 0, 0, '0, '0);
      idle();
      chk("row0_ignored_init_wr", mem_dout, 128'd0);

      bw_w2 = 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000;
      step(1'b0, 1'b1, 0, 5, bw_w2, '1);
      step(1'b1, 1'b0, 0, 5, '0, '0);
      idle();
      chk("masked_dout", mem_dout, 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000);
      chk("masked_serr", {124'd0, mem_serr}, 128'd0);

      step(1'b0, 1'b1, 0, 7, '1, {4{32'hAAAA_AAAA}});
      step(1'b1, 1'b1, 0, 7, '1, {4{32'h5555_5555}});
      step(1'b1, 1'b0, 0, 7, '0, '0);
      chk("rf_old", mem_dout, {4{32'hAAAA_AAAA}});
      idle();
      chk("rf_new", mem_dout, {4{32'h5555_5555}});

      step(1'b0, 1'b1, 3, 0, '1, '1);
      step(1'b1, 1'b0, 3, 0, '0, '0);
      step(1'b1, 1'b0, 0, 0, '0, '0);
      chk("oor_dout", mem_dout, 128'd0);
      chk("oor_serr", {124'd0, mem_serr}, 128'hF);
      step(1'b1, 1'b0, 1, 0, '0, '0);
      chk("oor_sa0", mem_dout, 128'd0);
      idle();
      chk("oor_sa1", mem_dout, 128'd0);

`ifdef INFRA_MEM_ERRINJ_EN
      inj_req = 1'b1; inj_addr = {4'd0, 8'd9}; inj_word = 2'd1;
      idle();
      inj_req = 1'b0;
      step(1'b1, 1'b0, 0, 9, '0, '0);
      step(1'b1, 1'b0, 0, 9, '0, '0);
      chk("inj_first", mem_dout, 128'h0000_0000_0000_0000_0000_0001_0000_0000);
      chk("inj_serr", {124'd0, mem_serr}, 128'h2);
      idle();
      chk("inj_second", mem_dout, 128'd0);
      chk("inj_second_serr", {124'd0, mem_serr}, 128'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         int dw, row;
         dw  = int'($urandom_range(0, 3));
         row = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(250, 255));
         inj_req  = ($urandom_range(0, 9) == 0);
         inj_addr = {4'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
         inj_word = 2'($urandom_range(0, 3));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dw, row,
              {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      end
      inj_req = 1'b0;
      repeat (3) idle();

      step(1'b0, 1'b1, 0, 7, '1, '1);
      step(1'b1, 1'b0, 0, 7, '0, '0);
      mem_read = 1'b0;
      rst_n = 1'b0;
      expq.delete();
      model.delete();
      inj_pend = 1'b0;
      last_dout = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         edge_n++;
         #1;
         chk("rst_mid_vld", {127'd0, mem_vld}, 128'd0);
         chk("rst_mid_dout", mem_dout, 128'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_init();
      step(1'b1, 1'b0, 0, 7, '0, '0);
      idle();
      chk("reinit_row7", mem_dout, 128'd0);
      chk("reinit_vld", {127'd0, mem_vld}, 128'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/infra_mem_dwsn_resp.md
# infra_mem_dwsn_resp

Memory-side responder for the ECC/down-select aligner: it takes the physical command bus the aligner drives (read, write, row address, bit-write mask, down-select, write data) and returns read data and per-word single-error flags after a fixed SRAM latency. It models the physical SRAM macro, including a self-zeroizing init sequence and a fixed read pipeline. It sits under the aligner in standalone benches and formal harnesses, and acts as the synthesizable stand-in macro for FPGA builds.

## Interface
- WIDTH, 32, logical word width
- ENAEXT, 0, external ECC; stored word width is WIDTH
- ENAPAR, 0, parity; stored word width is WIDTH+1
- ENAECC, 0, ECC; stored word width is WIDTH+ECCWDTH
- ECCWDTH, 7, ECC check bits
- MEMWDTH, derived, ENAEXT ? WIDTH : ENAPAR ? WIDTH+1 : ENAECC ? WIDTH+ECCWDTH : WIDTH
- NUMWRDS, 4, words per physical row
- NUMSROW, 256, rows per sub-array
- BITSROW, 8, row address width
- NUMDWSN, 2, implemented sub-arrays selected by mem_dwsn
- BITDWSN, 4, down-select width
- SRAM_DELAY, 2, read latency in cycles; minimum 1

Ports:
- clk, input, 1, clock
- rst, input, 1, reset: asynchronous, active-low
- mem_read, input, 1, read strobe
- mem_write, input, 1, write strobe
- mem_addr, input, BITSROW, row address
- mem_bw, input, NUMWRDS*MEMWDTH, per-bit write enable
- mem_dwsn, input, BITDWSN, sub-array select
- mem_din, input, NUMWRDS*MEMWDTH, write data
- mem_dout, output, NUMWRDS*MEMWDTH, read data
- mem_serr, output, NUMWRDS, per-word single-error flag
- mem_vld, output, 1, mem_dout and mem_serr valid this cycle
- mem_rdy, output, 1, init complete; commands are accepted
- inj_req, input, 1, error-inject request (used only with the macro)
- inj_addr, input, BITDWSN+BITSROW, {dwsn, row} inject target
- inj_word, input, 2 bits (log2 NUMWRDS), word to corrupt

## Operation
- Storage: NUMDWSN*NUMSROW rows, each NUMWRDS*MEMWDTH bits, indexed {mem_dwsn, mem_addr}. The array itself has no reset.
- FSM states:
  - INIT: entered on reset assertion. A counter walks the linear index 0..NUMDWSN*NUMSROW-1, writing zero one row per cycle. mem_rdy=0. Commands are ignored.
  - READY: entered the cycle after the last row is written. mem_rdy=1.
  - Reset asserted in any state returns the FSM to INIT with the counter at 0.
- Write (READY, mem_write=1): row[i] <= mem_bw[i] ? mem_din[i] : row[i], bit by bit.
- Read (READY, mem_read=1): the row is captured and pushed into a SRAM_DELAY-deep valid/data pipeline.
- Read and write on the same row in the same cycle: read-first. The read returns pre-write data and the write takes effect.
- Out-of-range select (mem_dwsn >= NUMDWSN) or out-of-range row (mem_addr >= NUMSROW):
  - write is dropped;
  - read returns all-zero data with mem_serr all-ones, on the normal latency.
- mem_dout holds its last value when mem_vld=0. mem_serr is 0 whenever mem_vld=0.
- Reset values: mem_dout=0, mem_serr=0, mem_vld=0, mem_rdy=0, pipeline cleared.

## Timing
- A read accepted at cycle T drives mem_vld=1 with data at T+SRAM_DELAY.
- Reads can be issued every cycle. Throughput is one per cycle with no stalls.
- A write at T is visible to a read issued at T+1.
- Init length: NUMDWSN*NUMSROW cycles after reset release. mem_rdy rises on the next cycle.
- Reads in flight when reset is asserted are discarded; no late mem_vld.

## Configuration
- INFRA_MEM_ERRINJ_EN defined:
  - inj_req=1 in READY arms a one-shot flag for (inj_addr, inj_word).
  - The next read of that row returns inj_word with bit 0 inverted and the matching mem_serr bit set.
  - The flag then clears.
  - Any write to that row also clears the flag.
  - A new inj_req replaces a pending flag.
- INFRA_MEM_ERRINJ_EN undefined: inj_* ports are ignored, there is no inject storage, and mem_serr is asserted only by the out-of-range rule.

## Test plan
- Init: release reset → mem_rdy=0 for exactly 512 cycles (defaults) then 1; a read of {1,255} returns 0 with mem_vld 2 cycles after issue.
- Masked write: write row 5, dwsn 0, din all-ones, bw with only word 2 enabled → read of row 5 returns only word 2 bits set; mem_serr=0.
- Back-to-back, read-first: write 0xA…A to row 7, then same-cycle read+write of 0x5…5 to row 7 → first read returns 0xA…A, next read returns 0x5…5.
- Out-of-range: write dwsn 3 row 0, then read dwsn 3 → mem_dout=0, mem_serr=4'b1111; sub-array 0 and 1 contents are unchanged.
- Reset mid-read: issue a read, assert rst the next cycle → mem_vld never rises; INIT restarts from row 0.
- INFRA_MEM_ERRINJ_EN: inject {0,9} word 1, then read row 9 twice → first read has word 1 bit 0 flipped and mem_serr=4'b0010; second read is clean.
